// File: rtl/if_id_reg_if.sv
// IF/ID bus: fetch-side inputs and decode-side outputs of the IF/ID register.
// master = fetch/control side, slave = the pipeline register itself.
interface if_id_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              IFIDwriteEn;
    logic              flush;
    logic [DATA_W-1:0] PC_plus4_in;
    logic [DATA_W-1:0] instr_in;
    logic              instr_valid_in;
    logic [DATA_W-1:0] PC_plus4_out;
    logic [DATA_W-1:0] instr_out;
    logic              valid_out;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output IFIDwriteEn, flush, PC_plus4_in, instr_in, instr_valid_in,
        input  PC_plus4_out, instr_out, valid_out, stall_cnt, bubble_cnt
    );

    modport slave (
        input  IFIDwriteEn, flush, PC_plus4_in, instr_in, instr_valid_in,
        output PC_plus4_out, instr_out, valid_out, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold, flush/invalid-fetch bubbles
// and saturating stall/bubble counters. Ports: clk, reset (sync, high), bus.
module if_id_reg #(
    parameter int              DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000,
    parameter int              CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    if_id_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  bubble_q;

    // Priority: reset > flush > stall > advance. A flush overrides a
    // simultaneous stall because the branch is older than the hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (bus.flush) begin
            pc_q    <= bus.PC_plus4_in;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            if (bubble_q != CNT_MAX)
                bubble_q <= bubble_q + 1'b1;
        end else if (!bus.IFIDwriteEn) begin
            if (stall_q != CNT_MAX)
                stall_q <= stall_q + 1'b1;
        end else begin
            pc_q <= bus.PC_plus4_in;
            if (bus.instr_valid_in) begin
                instr_q <= bus.instr_in;
                valid_q <= 1'b1;
            end else begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
                if (bubble_q != CNT_MAX)
                    bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign bus.PC_plus4_out = pc_q;
    assign bus.instr_out    = instr_q;
    assign bus.valid_out    = valid_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.bubble_cnt   = bubble_q;
endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: directed vectors push hand-computed
// expectations; a monitor pops and compares after every rising edge.
module tb_if_id_reg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic              valid;
        logic [CNT_W-1:0]  stall;
        logic [CNT_W-1:0]  bubble;
    } exp_t;

    logic clk;
    logic reset;
    exp_t q[$];
    int   vectors;
    int   miscompares;

    if_id_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    if_id_reg #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply(
        input logic              r,
        input logic              we,
        input logic              fl,
        input logic [DATA_W-1:0] pc,
        input logic [DATA_W-1:0] ins,
        input logic              vin,
        input logic [DATA_W-1:0] epc,
        input logic [DATA_W-1:0] eins,
        input logic              ev,
        input int                es,
        input int                eb
    );
        exp_t e;
        @(negedge clk);
        reset              = r;
        bus.IFIDwriteEn    = we;
        bus.flush          = fl;
        bus.PC_plus4_in    = pc;
        bus.instr_in       = ins;
        bus.instr_valid_in = vin;
        e.pc     = epc;
        e.instr  = eins;
        e.valid  = ev;
        e.stall  = CNT_W'(es);
        e.bubble = CNT_W'(eb);
        q.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge after stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (bus.PC_plus4_out !== e.pc) begin
                    miscompares++;
                    $display("FAIL v%0d pc: got %h want %h", vectors, bus.PC_plus4_out, e.pc);
                end
                if (bus.instr_out !== e.instr) begin
                    miscompares++;
                    $display("FAIL v%0d instr: got %h want %h", vectors, bus.instr_out, e.instr);
                end
                if (bus.valid_out !== e.valid) begin
                    miscompares++;
                    $display("FAIL v%0d valid: got %b want %b", vectors, bus.valid_out, e.valid);
                end
                if (bus.stall_cnt !== e.stall) begin
                    miscompares++;
                    $display("FAIL v%0d stall_cnt: got %0d want %0d", vectors, bus.stall_cnt, e.stall);
                end
                if (bus.bubble_cnt !== e.bubble) begin
                    miscompares++;
                    $display("FAIL v%0d bubble_cnt: got %0d want %0d", vectors, bus.bubble_cnt, e.bubble);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset              = 1'b1;
        bus.IFIDwriteEn    = 1'b0;
        bus.flush          = 1'b0;
        bus.PC_plus4_in    = '0;
        bus.instr_in       = '0;
        bus.instr_valid_in = 1'b0;

        // reset for two cycles, release into a stall
        apply(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        apply(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        apply(0, 0, 0, 32'h4, 32'hFFFF_FFFF, 1, 32'h0, 32'h0, 0, 1, 0);

        // advance two instructions
        apply(0, 1, 0, 32'h04, 32'h8C22_0000, 1, 32'h04, 32'h8C22_0000, 1, 1, 0);
        apply(0, 1, 0, 32'h08, 32'h0043_0820, 1, 32'h08, 32'h0043_0820, 1, 1, 0);

        // fresh reset, load, then three stalled cycles
        apply(1, 1, 0, 32'h50, 32'h1, 1, 32'h0, 32'h0, 0, 0, 0);
        apply(0, 1, 0, 32'h0C, 32'h8C22_0000, 1, 32'h0C, 32'h8C22_0000, 1, 0, 0);
        for (int i = 1; i <= 3; i++)
            apply(0, 0, 0, 32'h10, 32'hDEAD_BEEF, 1, 32'h0C, 32'h8C22_0000, 1, i, 0);

        // flush beats stall
        apply(0, 0, 1, 32'h10, 32'h1234_5678, 1, 32'h10, 32'h0, 0, 3, 1);

        // invalid fetch bubble
        apply(0, 1, 0, 32'h14, 32'hAAAA_5555, 0, 32'h14, 32'h0, 0, 3, 2);

        // flush while advancing
        apply(0, 1, 1, 32'h18, 32'h0000_0001, 1, 32'h18, 32'h0, 0, 3, 3);

        // held entry keeps valid even if fetch goes invalid during stall
        apply(0, 1, 0, 32'h1C, 32'h0022_1820, 1, 32'h1C, 32'h0022_1820, 1, 3, 3);
        apply(0, 0, 0, 32'h20, 32'h0, 0, 32'h1C, 32'h0022_1820, 1, 4, 3);

        // stall saturation, then reset mid-stall
        apply(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 1; i <= 20; i++)
            apply(0, 0, 0, 32'h40, 32'h3, 1, 32'h0, 32'h0, 0, (i > 15) ? 15 : i, 0);
        apply(1, 0, 0, 32'h44, 32'h3, 1, 32'h0, 32'h0, 0, 0, 0);

        // first capture right after reset release
        apply(0, 1, 0, 32'h20, 32'h1111_1111, 1, 32'h20, 32'h1111_1111, 1, 0, 0);

        // bubble saturation via repeated flushes, then reset mid-flush
        for (int i = 1; i <= 17; i++)
            apply(0, 1, 1, DATA_W'(32'h100 + 4 * i), 32'h7, 1,
                  DATA_W'(32'h100 + 4 * i), 32'h0, 0, 0, (i > 15) ? 15 : i);
        apply(1, 1, 1, 32'h200, 32'h7, 1, 32'h0, 32'h0, 0, 0, 0);

        // drain scoreboard, bounded
        for (int i = 0; i < 5 && q.size() != 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
